// File: rtl/ps2_pkg.sv
// rtl/ps2_pkg.sv - shared PS/2 Set 2 constants, state type and helper functions
package ps2_pkg;

    // Set 2 make codes for the supported keys
    localparam logic [7:0] KEY_0     = 8'h45;
    localparam logic [7:0] KEY_1     = 8'h16;
    localparam logic [7:0] KEY_2     = 8'h1E;
    localparam logic [7:0] KEY_3     = 8'h26;
    localparam logic [7:0] KEY_4     = 8'h25;
    localparam logic [7:0] KEY_5     = 8'h2E;
    localparam logic [7:0] KEY_6     = 8'h36;
    localparam logic [7:0] KEY_7     = 8'h3D;
    localparam logic [7:0] KEY_8     = 8'h3E;
    localparam logic [7:0] KEY_9     = 8'h46;
    localparam logic [7:0] KEY_A     = 8'h1C;
    localparam logic [7:0] KEY_B     = 8'h32;
    localparam logic [7:0] KEY_C     = 8'h21;
    localparam logic [7:0] KEY_D     = 8'h23;
    localparam logic [7:0] KEY_E     = 8'h24;
    localparam logic [7:0] KEY_F     = 8'h2B;
    localparam logic [7:0] KEY_ENTER = 8'h5A;

    localparam logic [7:0] BREAK_PREFIX = 8'hF0;
    localparam logic [7:0] ASCII_CR     = 8'h0D;

    // start + 8 data + parity + stop
    localparam int FRAME_BITS = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FRAME = 2'd2,
        ST_GAP   = 2'd3
    } tx_state_e;

    typedef struct packed {
        logic       ok;
        logic [7:0] code;
    } map_result_t;

    // ASCII to Set 2 make code; ok=0 for anything without a key
    function automatic map_result_t ascii_to_make(input logic [7:0] ascii);
        map_result_t r;
        r.ok   = 1'b1;
        r.code = 8'h00;
        case (ascii)
            8'h30:        r.code = KEY_0;
            8'h31:        r.code = KEY_1;
            8'h32:        r.code = KEY_2;
            8'h33:        r.code = KEY_3;
            8'h34:        r.code = KEY_4;
            8'h35:        r.code = KEY_5;
            8'h36:        r.code = KEY_6;
            8'h37:        r.code = KEY_7;
            8'h38:        r.code = KEY_8;
            8'h39:        r.code = KEY_9;
            8'h41, 8'h61: r.code = KEY_A;
            8'h42, 8'h62: r.code = KEY_B;
            8'h43, 8'h63: r.code = KEY_C;
            8'h44, 8'h64: r.code = KEY_D;
            8'h45, 8'h65: r.code = KEY_E;
            8'h46, 8'h66: r.code = KEY_F;
            ASCII_CR:     r.code = KEY_ENTER;
            default:      r.ok   = 1'b0;
        endcase
        return r;
    endfunction

    // Line level for a given bit slot of a frame carrying 'data'
    function automatic logic frame_bit(input logic [7:0] data, input logic [3:0] slot);
        logic b;
        if (slot == 4'd0) begin
            b = 1'b0;
        end else if (slot <= 4'd8) begin
            b = data[3'(slot - 4'd1)];
        end else if (slot == 4'd9) begin
            b = ~^data;
        end else begin
            b = 1'b1;
        end
        return b;
    endfunction

endpackage

// File: rtl/ps2_frame_tx.sv
// rtl/ps2_frame_tx.sv - serialises one byte as an 11-bit PS/2 device frame
module ps2_frame_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] data,
    output logic       done,
    output logic       ps2_clk_o,
    output logic       ps2_data_o
);

    localparam logic [15:0] HALF_LAST = 16'(HALF_PERIOD - 1);
    localparam logic [3:0]  LAST_SLOT = 4'(FRAME_BITS - 1);

    logic        active_q, active_d;
    logic        low_q, low_d;
    logic [15:0] half_cnt_q, half_cnt_d;
    logic [3:0]  slot_q, slot_d;
    logic [7:0]  byte_q, byte_d;
    logic        clk_q, clk_d;
    logic        dat_q, dat_d;
    logic        half_end;

    assign half_end   = (half_cnt_q == HALF_LAST);
    assign done       = active_q && low_q && half_end && (slot_q == LAST_SLOT);
    assign ps2_clk_o  = clk_q;
    assign ps2_data_o = dat_q;

    // Slot sequencing: each slot is a high half then a low half; data moves only at slot start
    always_comb begin
        active_d   = active_q;
        low_d      = low_q;
        half_cnt_d = half_cnt_q;
        slot_d     = slot_q;
        byte_d     = byte_q;
        clk_d      = clk_q;
        dat_d      = dat_q;
        if (!active_q) begin
            if (start) begin
                active_d   = 1'b1;
                byte_d     = data;
                slot_d     = 4'd0;
                low_d      = 1'b0;
                half_cnt_d = 16'd0;
                clk_d      = 1'b1;
                dat_d      = frame_bit(data, 4'd0);
            end
        end else if (!half_end) begin
            half_cnt_d = half_cnt_q + 16'd1;
        end else begin
            half_cnt_d = 16'd0;
            if (!low_q) begin
                low_d = 1'b1;
                clk_d = 1'b0;
            end else begin
                low_d = 1'b0;
                clk_d = 1'b1;
                if (slot_q == LAST_SLOT) begin
                    active_d = 1'b0;
                    dat_d    = 1'b1;
                end else begin
                    slot_d = slot_q + 4'd1;
                    dat_d  = frame_bit(byte_q, slot_q + 4'd1);
                end
            end
        end
    end

    // State registers; reset releases both lines and drops any frame in flight
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q   <= 1'b0;
            low_q      <= 1'b0;
            half_cnt_q <= 16'd0;
            slot_q     <= 4'd0;
            byte_q     <= 8'd0;
            clk_q      <= 1'b1;
            dat_q      <= 1'b1;
        end else begin
            active_q   <= active_d;
            low_q      <= low_d;
            half_cnt_q <= half_cnt_d;
            slot_q     <= slot_d;
            byte_q     <= byte_d;
            clk_q      <= clk_d;
            dat_q      <= dat_d;
        end
    end

endmodule

// File: rtl/ascii_to_ps2_tx.sv
// rtl/ascii_to_ps2_tx.sv - ASCII character to PS/2 make/break keystroke generator
module ascii_to_ps2_tx
    import ps2_pkg::*;
#(
    parameter int HALF_PERIOD = 2000,
    parameter int GAP_CYCLES  = 10000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] ascii_in,
    input  logic       ascii_valid,
    output logic       ascii_ready,
    output logic       ps2_clk_o,
    output logic       ps2_data_o,
    output logic       busy,
    output logic       unsupported
);

    localparam logic [15:0] GAP_LAST = 16'(GAP_CYCLES - 1);

    tx_state_e   state_q, state_d;
    logic [1:0]  byte_idx_q, byte_idx_d;
    logic [15:0] gap_cnt_q, gap_cnt_d;
    logic [7:0]  code_q, code_d;
    logic        ready_q, ready_d;
    logic        busy_q, busy_d;
    logic        unsup_q, unsup_d;

    map_result_t map;
    logic        take;
    logic        frame_start;
    logic [7:0]  frame_byte;
    logic        frame_done;

    assign map         = ascii_to_make(ascii_in);
    assign take        = ascii_valid && ready_q;
    assign frame_start = (state_q == ST_LOAD);
    assign frame_byte  = (byte_idx_q == 2'd1) ? BREAK_PREFIX : code_q;

    assign ascii_ready = ready_q;
    assign busy        = busy_q;
    assign unsupported = unsup_q;

    ps2_frame_tx #(
        .HALF_PERIOD(HALF_PERIOD)
    ) u_frame_tx (
        .clk       (clk),
        .reset     (reset),
        .start     (frame_start),
        .data      (frame_byte),
        .done      (frame_done),
        .ps2_clk_o (ps2_clk_o),
        .ps2_data_o(ps2_data_o)
    );

    // Keystroke sequencer: make, F0, make, each followed by an idle gap
    always_comb begin
        state_d    = state_q;
        byte_idx_d = byte_idx_q;
        gap_cnt_d  = gap_cnt_q;
        code_d     = code_q;
        unsup_d    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (take) begin
                    if (map.ok) begin
                        state_d    = ST_LOAD;
                        code_d     = map.code;
                        byte_idx_d = 2'd0;
                    end else begin
                        unsup_d = 1'b1;
                    end
                end
            end
            ST_LOAD: begin
                state_d = ST_FRAME;
            end
            ST_FRAME: begin
                if (frame_done) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = 16'd0;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q == GAP_LAST) begin
                    gap_cnt_d = 16'd0;
                    if (byte_idx_q == 2'd2) begin
                        state_d = ST_IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 2'd1;
                        state_d    = ST_LOAD;
                    end
                end else begin
                    gap_cnt_d = gap_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        ready_d = (state_d == ST_IDLE);
        busy_d  = (state_d != ST_IDLE);
    end

    // Sequencer registers with registered handshake/status outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            byte_idx_q <= 2'd0;
            gap_cnt_q  <= 16'd0;
            code_q     <= 8'd0;
            ready_q    <= 1'b1;
            busy_q     <= 1'b0;
            unsup_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            gap_cnt_q  <= gap_cnt_d;
            code_q     <= code_d;
            ready_q    <= ready_d;
            busy_q     <= busy_d;
            unsup_q    <= unsup_d;
        end
    end

endmodule

// File: tb/tb_ascii_to_ps2_tx.sv
// tb/tb_ascii_to_ps2_tx.sv - self-checking bench for ascii_to_ps2_tx
module tb_ascii_to_ps2_tx;

    localparam int HP         = 4;
    localparam int GAP        = 8;
    localparam int KEY_CYCLES = 3 * (1 + 22 * HP + GAP);

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] ascii_in;
    logic       ascii_valid;
    logic       ascii_ready;
    logic       ps2_clk_o;
    logic       ps2_data_o;
    logic       busy;
    logic       unsupported;

    int tests = 0;
    int fails = 0;

    logic [10:0] rxq[$];
    logic [10:0] bitbuf = 11'd0;
    int          nbits  = 0;
    int          falls  = 0;
    logic        prev_clk = 1'b1;

    logic [7:0] digit_codes[10] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D, 8'h3E, 8'h46};
    logic [7:0] hex_codes[6]    = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};
    logic [7:0] pool[8]         = '{8'h30, 8'h39, 8'h42, 8'h66, 8'h0D, 8'h47, 8'h7A, 8'h2F};

    always #5 clk = ~clk;

    ascii_to_ps2_tx #(
        .HALF_PERIOD(HP),
        .GAP_CYCLES (GAP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .ascii_in   (ascii_in),
        .ascii_valid(ascii_valid),
        .ascii_ready(ascii_ready),
        .ps2_clk_o  (ps2_clk_o),
        .ps2_data_o (ps2_data_o),
        .busy       (busy),
        .unsupported(unsupported)
    );

    // Host-side receiver: sample data on each falling PS/2 clock, 11 bits per frame
    always @(negedge clk) begin
        if (reset) begin
            nbits    = 0;
            prev_clk = 1'b1;
        end else begin
            if (prev_clk && !ps2_clk_o) begin
                falls++;
                bitbuf[nbits] = ps2_data_o;
                nbits++;
                if (nbits == 11) begin
                    rxq.push_back(bitbuf);
                    nbits = 0;
                end
            end
            prev_clk = ps2_clk_o;
        end
    end

    function automatic logic [8:0] ref_map(input logic [7:0] a);
        int v;
        v = int'(a);
        if (v >= 'h30 && v <= 'h39) return {1'b1, digit_codes[v - 'h30]};
        if (v >= 'h41 && v <= 'h46) return {1'b1, hex_codes[v - 'h41]};
        if (v >= 'h61 && v <= 'h66) return {1'b1, hex_codes[v - 'h61]};
        if (v == 'h0D) return {1'b1, 8'h5A};
        return 9'd0;
    endfunction

    function automatic logic [10:0] frame_of(input logic [7:0] b);
        return {1'b1, ~^b, b, 1'b0};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic transfer(input logic [7:0] c);
        int n;
        ascii_in    = c;
        ascii_valid = 1'b1;
        n = 0;
        while (!ascii_ready && n < 1000) begin
            tick();
            n++;
        end
        check("xfer_ready", {31'd0, ascii_ready}, 32'd1);
        tick();
    endtask

    task automatic wait_ready(output int n);
        n = 0;
        while (!ascii_ready && n < 2000) begin
            tick();
            n++;
        end
    endtask

    task automatic expect_keystroke(input string tag, input logic [7:0] code);
        logic [10:0] got;
        for (int k = 0; k < 3; k++) begin
            if (rxq.size() > 0) got = rxq.pop_front();
            else got = 11'bx;
            check($sformatf("%s_frame%0d", tag, k), {21'd0, got},
                  {21'd0, frame_of((k == 1) ? 8'hF0 : code)});
        end
    endtask

    initial begin
        int          n;
        logic [7:0]  c;
        logic [8:0]  m;
        logic [10:0] f;
        int          f0;
        logic        ready_ok;

        reset       = 1'b1;
        ascii_valid = 1'b0;
        ascii_in    = 8'h00;
        repeat (3) tick();
        check("rst_clk", {31'd0, ps2_clk_o}, 32'd1);
        check("rst_data", {31'd0, ps2_data_o}, 32'd1);
        check("rst_ready", {31'd0, ascii_ready}, 32'd1);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_unsup", {31'd0, unsupported}, 32'd0);
        reset = 1'b0;
        tick();

        // 1: '1' -> 16 F0 16, exact bit patterns and latency
        transfer(8'h31);
        ascii_valid = 1'b0;
        check("t1_busy", {31'd0, busy}, 32'd1);
        check("t1_ready_low", {31'd0, ascii_ready}, 32'd0);
        wait_ready(n);
        check("t1_latency", n, KEY_CYCLES);
        check("t1_nframes", rxq.size(), 3);
        f = (rxq.size() > 0) ? rxq.pop_front() : 11'bx;
        check("t1_bits16a", {21'd0, f}, {21'd0, 11'b10000101100});
        f = (rxq.size() > 0) ? rxq.pop_front() : 11'bx;
        check("t1_bitsF0", {21'd0, f}, {21'd0, 11'b11111100000});
        f = (rxq.size() > 0) ? rxq.pop_front() : 11'bx;
        check("t1_bits16b", {21'd0, f}, {21'd0, 11'b10000101100});
        check("t1_busy_end", {31'd0, busy}, 32'd0);

        // 2: 'a' then 'E' with valid held
        transfer(8'h61);
        ascii_in = 8'h45;
        wait_ready(n);
        check("t2_latency_a", n, KEY_CYCLES);
        tick();
        check("t2_accept_e", {31'd0, ascii_ready}, 32'd0);
        ascii_valid = 1'b0;
        wait_ready(n);
        check("t2_latency_e", n, KEY_CYCLES);
        expect_keystroke("t2_a", 8'h1C);
        expect_keystroke("t2_e", 8'h24);

        // 3: CR -> 5A F0 5A, parity bit 1
        transfer(8'h0D);
        ascii_valid = 1'b0;
        wait_ready(n);
        check("t3_latency", n, KEY_CYCLES);
        f = (rxq.size() > 0) ? rxq[0] : 11'bx;
        check("t3_parity", {31'd0, f[9]}, 32'd1);
        expect_keystroke("t3", 8'h5A);

        // 4: 'G' is unsupported
        f0 = falls;
        transfer(8'h47);
        ascii_valid = 1'b0;
        check("t4_pulse", {31'd0, unsupported}, 32'd1);
        ready_ok = 1'b1;
        tick();
        check("t4_pulse_end", {31'd0, unsupported}, 32'd0);
        repeat (20) begin
            if (!ascii_ready) ready_ok = 1'b0;
            tick();
        end
        check("t4_ready_held", {31'd0, ready_ok}, 32'd1);
        check("t4_no_clk", falls - f0, 0);
        check("t4_no_frames", rxq.size(), 0);

        // 5: reset during data[3] slot of the F0 frame
        transfer(8'h35);
        ascii_valid = 1'b0;
        repeat (133) tick();
        reset = 1'b1;
        tick();
        check("t5_clk", {31'd0, ps2_clk_o}, 32'd1);
        check("t5_data", {31'd0, ps2_data_o}, 32'd1);
        check("t5_busy", {31'd0, busy}, 32'd0);
        check("t5_ready", {31'd0, ascii_ready}, 32'd1);
        tick();
        reset = 1'b0;
        check("t5_partial", rxq.size(), 1);
        f = (rxq.size() > 0) ? rxq.pop_front() : 11'bx;
        check("t5_first", {21'd0, f}, {21'd0, frame_of(8'h2E)});
        rxq.delete();
        transfer(8'h30);
        ascii_valid = 1'b0;
        wait_ready(n);
        check("t5_latency", n, KEY_CYCLES);
        expect_keystroke("t5_0", 8'h45);

        // 6: inputs churn while busy
        c = pool[$urandom_range(0, 4)];
        m = ref_map(c);
        transfer(c);
        n = 0;
        while (!ascii_ready && n < 2000) begin
            ascii_in    = 8'($urandom);
            ascii_valid = 1'($urandom);
            tick();
            n++;
        end
        ascii_valid = 1'b0;
        check("t6_latency", n, KEY_CYCLES);
        expect_keystroke("t6", m[7:0]);
        repeat (30) tick();
        check("t6_no_extra", rxq.size(), 0);
        check("t6_idle", {31'd0, busy}, 32'd0);

        // 7: random characters against the reference map
        for (int i = 0; i < 6; i++) begin
            if ($urandom_range(0, 1) == 0) c = pool[$urandom_range(0, 7)];
            else c = 8'($urandom);
            m = ref_map(c);
            transfer(c);
            ascii_valid = 1'b0;
            if (m[8]) begin
                check($sformatf("r%0d_unsup", i), {31'd0, unsupported}, 32'd0);
                wait_ready(n);
                check($sformatf("r%0d_latency", i), n, KEY_CYCLES);
                expect_keystroke($sformatf("r%0d", i), m[7:0]);
            end else begin
                check($sformatf("r%0d_unsup", i), {31'd0, unsupported}, 32'd1);
                tick();
                check($sformatf("r%0d_ready", i), {31'd0, ascii_ready}, 32'd1);
                check($sformatf("r%0d_noframe", i), rxq.size(), 0);
            end
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
